// File: rtl/main_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes and mux selects, and counts retired instructions.
module main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; combinational blocks below use blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through the block can leave a value unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        retire    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                // The write repeats while stalled; memory commits it on mem_ready.
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase

        // Strobes must not fire while reset is held, even from a live state.
        if (reset) begin
            PCUpdate = 1'b0;
            Branch   = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            AdrSrc   = 1'b0;
            retire   = 1'b0;
        end
    end

    always_comb begin
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
        instret_d = instret_q + CNT_W'(retire);
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule
